// File: rtl/fir_axil_cfg_master.sv
// Single-outstanding AXI-Lite initiator that programs and reads back the FIR configuration/tap space.
// Optional watchdog per channel phase is enabled with the AXIL_TIMEOUT_EN macro.
module fir_axil_cfg_master #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pTIMEOUT    = 255
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [pADDR_WIDTH-1:0] cmd_addr,
   input  logic [pDATA_WIDTH-1:0] cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [pDATA_WIDTH-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [pDATA_WIDTH-1:0] rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD_A = 3'd2,
      RD_D = 3'd3,
      RSP  = 3'd4
   } state_t;

   state_t state_r;
   logic   aw_done_s;
   logic   w_done_s;

   // A channel counts as done once its valid has dropped or it is handshaking this cycle.
   assign aw_done_s = !awvalid || awready;
   assign w_done_s  = !wvalid  || wready;

`ifdef AXIL_TIMEOUT_EN
   localparam int            CW       = $clog2(pTIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(pTIMEOUT - 1);
   localparam logic [CW-1:0] TMO_ONE  = CW'(1);

   logic [CW-1:0] tmo_cnt_r;
   logic          tmo_hit_s;

   assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
`endif

   // Transaction sequencer; every port output is a flop of this block.
   always_ff @(posedge axis_clk or posedge axis_rst) begin
      if (axis_rst) begin
         state_r   <= IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= {pDATA_WIDTH{1'b0}};
         rsp_err   <= 1'b0;
         awvalid   <= 1'b0;
         awaddr    <= {pADDR_WIDTH{1'b0}};
         wvalid    <= 1'b0;
         wdata     <= {pDATA_WIDTH{1'b0}};
         arvalid   <= 1'b0;
         araddr    <= {pADDR_WIDTH{1'b0}};
         rready    <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
         tmo_cnt_r <= {CW{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
                  tmo_cnt_r <= {CW{1'b0}};
`endif
                  if (cmd_write) begin
                     awaddr  <= cmd_addr;
                     wdata   <= cmd_wdata;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state_r <= WR;
                  end else begin
                     araddr  <= cmd_addr;
                     arvalid <= 1'b1;
                     state_r <= RD_A;
                  end
               end
            end

            WR: begin
               if (awvalid && awready) begin
                  awvalid <= 1'b0;
               end
               if (wvalid && wready) begin
                  wvalid <= 1'b0;
               end
               if (aw_done_s && w_done_s) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= {pDATA_WIDTH{1'b0}};
                  state_r   <= RSP;
               end
`ifdef AXIL_TIMEOUT_EN
               else if (tmo_hit_s) begin
                  awvalid   <= 1'b0;
                  wvalid    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= {pDATA_WIDTH{1'b0}};
                  rsp_err   <= 1'b1;
                  state_r   <= RSP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
               end
`endif
            end

            RD_A: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state_r <= RD_D;
`ifdef AXIL_TIMEOUT_EN
                  tmo_cnt_r <= {CW{1'b0}};
               end else if (tmo_hit_s) begin
                  arvalid   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= {pDATA_WIDTH{1'b0}};
                  rsp_err   <= 1'b1;
                  state_r   <= RSP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
`endif
               end
            end

            RD_D: begin
               // rready is high throughout this state, so rvalid alone completes R.
               if (rvalid) begin
                  rready    <= 1'b0;
                  rsp_rdata <= rdata;
                  rsp_valid <= 1'b1;
                  state_r   <= RSP;
`ifdef AXIL_TIMEOUT_EN
               end else if (tmo_hit_s) begin
                  rready    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= {pDATA_WIDTH{1'b0}};
                  rsp_err   <= 1'b1;
                  state_r   <= RSP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
`endif
               end
            end

            RSP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_r   <= IDLE;
               end
            end

            default: begin
               cmd_ready <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               awvalid   <= 1'b0;
               wvalid    <= 1'b0;
               arvalid   <= 1'b0;
               rready    <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
